// File: rtl/ram_cmd_seq.sv
// ram_cmd_seq: executes RAM bursts issued by the RS-232C command block.
//
// Purpose:
//   Buffers write bytes in a small FIFO. On a launch pulse it runs a WRITE
//   (drain the FIFO), READ (RD_LEN bytes returned on the response stream) or
//   FILL (FILL_LEN copies of one byte) burst against the frame-RAM arbiter.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ram_cmd_*          command inputs: start pulse, op, address, write-byte push
//   mem_*              arbiter port: req/we/addr/wdata out, ack/rdata in
//   rsp_ram_rd*        response byte, strobe and write-pointer reset pulse
//   busy, done, err    status: in progress, completion pulse, sticky error
//
// Optional feature:
//   RAM_CMD_TIMEOUT_EN - abandon a burst when mem_ack is missing for TMO_CYC
//   cycles of mem_req (sets err, flushes the FIFO, finishes through DONE).
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | waiting for ram_cmd_startp
// S_WR_BURST   | writing FIFO bytes, one per mem_ack
// S_RD_RSTW    | one-cycle response write-pointer reset
// S_RD_BURST   | reading RD_LEN bytes, each echoed on the response stream
// S_FILL_BURST | writing the latched fill byte FILL_LEN times
// S_DONE       | one-cycle completion pulse

module ram_cmd_seq #(
    parameter int FIFO_AW  = 6,
    parameter int RD_LEN   = 16,
    parameter int FILL_LEN = 256,
    parameter int TMO_CYC  = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_cmd_startp,
    input  logic [2:0]  ram_ope_sel,
    input  logic [21:0] ram_cmd_ad,
    input  logic [7:0]  ram_cmd_rd,
    input  logic        ram_cmd_rd_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  rsp_ram_rd,
    output logic        rsp_ram_rd_we,
    output logic        rsp_ram_rd_rstw,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int FIFO_DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_BURST,
        S_RD_RSTW,
        S_RD_BURST,
        S_FILL_BURST,
        S_DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [7:0]           r_fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   r_fifo_wp, r_fifo_rp;
    logic [FIFO_AW:0]     r_fifo_cnt;
    logic [21:0]          r_addr;
    logic [15:0]          r_cnt;
    logic [7:0]           r_fill;
    logic [7:0]           r_rsp_data;
    logic                 r_rsp_we;
    logic                 r_err;

    logic                 w_req, w_ack, w_start, w_burst_wr, w_last;
    logic                 w_fifo_full, w_push, w_push_drop, w_pop, w_fifo_flush;
    logic                 w_op_illegal, w_err_set, w_tmo_hit;
    logic [7:0]           w_fifo_head;

    assign w_req       = (r_state == S_WR_BURST) || (r_state == S_RD_BURST) ||
                         (r_state == S_FILL_BURST);
    assign w_burst_wr  = (r_state == S_WR_BURST) || (r_state == S_FILL_BURST);
    assign w_ack       = mem_ack & w_req;
    assign w_start     = ram_cmd_startp & (r_state == S_IDLE);
    assign w_last      = (r_cnt == 16'd1);
    assign w_fifo_full = (r_fifo_cnt == (FIFO_AW+1)'(FIFO_DEPTH));
    assign w_fifo_head = r_fifo_mem[r_fifo_rp];
    // Pushes are refused while a burst is consuming the FIFO.
    assign w_push      = ram_cmd_rd_we & ~w_burst_wr & ~w_fifo_full;
    assign w_push_drop = ram_cmd_rd_we & (w_burst_wr | w_fifo_full);
    assign w_err_set   = w_push_drop | w_op_illegal | w_tmo_hit;

    assign mem_req         = w_req;
    assign mem_we          = w_burst_wr;
    assign mem_addr        = r_addr;
    assign mem_wdata       = (r_state == S_FILL_BURST) ? r_fill :
                             (r_state == S_WR_BURST)   ? w_fifo_head : 8'h00;
    assign rsp_ram_rd      = r_rsp_data;
    assign rsp_ram_rd_we   = r_rsp_we;
    assign rsp_ram_rd_rstw = (r_state == S_RD_RSTW);
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign err             = r_err;

`ifdef RAM_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] r_tmo;

    // Down-counter reloaded whenever no request is pending or an ack arrives.
    always_ff @(posedge clk) begin
        if (rst || !w_req || mem_ack) begin
            r_tmo <= TMO_W'(TMO_CYC - 1);
        end else if (r_tmo != '0) begin
            r_tmo <= r_tmo - TMO_W'(1);
        end
    end

    assign w_tmo_hit = w_req & ~mem_ack & (r_tmo == '0);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TMO_CYC != 0);
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_fifo_flush = 1'b0;
        w_op_illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ram_cmd_startp) begin
                    case (ram_ope_sel)
                        3'd0: w_state_nxt = S_IDLE;
                        3'd1: w_state_nxt = (r_fifo_cnt != '0) ? S_WR_BURST : S_DONE;
                        3'd2: w_state_nxt = S_RD_RSTW;
                        3'd3: begin
                            w_state_nxt  = S_FILL_BURST;
                            w_fifo_flush = 1'b1;
                        end
                        default: begin
                            w_state_nxt  = S_DONE;
                            w_op_illegal = 1'b1;
                        end
                    endcase
                end
            end
            S_WR_BURST: begin
                if (w_ack) begin
                    w_pop = 1'b1;
                    if (w_last) w_state_nxt = S_DONE;
                end
            end
            S_RD_RSTW:    w_state_nxt = S_RD_BURST;
            S_RD_BURST:   if (w_ack && w_last) w_state_nxt = S_DONE;
            S_FILL_BURST: if (w_ack && w_last) w_state_nxt = S_DONE;
            S_DONE:       w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
        if (w_tmo_hit) begin
            w_state_nxt  = S_DONE;
            w_fifo_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_fifo_wp] <= ram_cmd_rd;
    end

    always_ff @(posedge clk) begin
        if (rst || w_fifo_flush) begin
            r_fifo_wp  <= '0;
            r_fifo_rp  <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_fifo_wp <= r_fifo_wp + FIFO_AW'(1);
            if (w_pop)  r_fifo_rp <= r_fifo_rp + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + (FIFO_AW+1)'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - (FIFO_AW+1)'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_cnt      <= '0;
            r_fill     <= '0;
            r_rsp_data <= '0;
            r_rsp_we   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rsp_we <= 1'b0;
            if ((r_state == S_RD_BURST) && w_ack) begin
                r_rsp_data <= mem_rdata;
                r_rsp_we   <= 1'b1;
            end
            if (w_start) begin
                r_addr <= ram_cmd_ad;
                case (ram_ope_sel)
                    3'd1:    r_cnt <= 16'(r_fifo_cnt);
                    3'd2:    r_cnt <= 16'(RD_LEN);
                    3'd3: begin
                        r_cnt  <= 16'(FILL_LEN);
                        r_fill <= (r_fifo_cnt != '0) ? w_fifo_head : 8'h00;
                    end
                    default: r_cnt <= r_cnt;
                endcase
            end else if (w_ack) begin
                // 22-bit address wraps naturally at the top of the RAM.
                r_addr <= r_addr + 22'd1;
                r_cnt  <= r_cnt - 16'd1;
            end
            r_err <= (w_start ? 1'b0 : r_err) | w_err_set;
        end
    end

endmodule
